// File: rtl/axi4l_rd_master.sv
// AXI4-Lite read master: one AR slot, credit-limited outstanding reads,
// in-order response FIFO and a sticky stall timeout.
module axi4l_rd_master #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned TMO_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_prot,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_resp,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic              busy,
    output logic              err_timeout
);
    localparam int unsigned PTR_W = $clog2(MAX_OUTST);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(MAX_OUTST);

    typedef enum logic {AR_IDLE = 1'b0, AR_BUSY = 1'b1} ar_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
    } rsp_beat_t;

    ar_state_t        state;
    logic [CNT_W-1:0] credits;
    logic [CNT_W-1:0] occupancy;
    logic [PTR_W:0]   wptr;
    logic [PTR_W:0]   rptr;
    rsp_beat_t        fifo_mem [MAX_OUTST];
    rsp_beat_t        head;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_nxt;
    logic             req_hs;
    logic             rsp_hs;
    logic             r_hs;
    logic             fifo_full;
    logic             fifo_empty;

    // A new request may ride the same edge that retires the current AR beat.
    assign req_ready = ((state == AR_IDLE) || arready) && (credits < CREDIT_MAX);
    assign req_hs    = req_valid && req_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign r_hs      = rvalid && rready;

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                        (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
    assign occupancy  = wptr - rptr;

    assign rready    = !fifo_full;
    assign rsp_valid = !fifo_empty;
    assign head      = fifo_mem[rptr[PTR_W-1:0]];
    assign rsp_data  = head.data;
    assign rsp_resp  = head.resp;
    assign busy      = (credits != '0) || arvalid;

    // AR slot: address/prot captured on request, held until arready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= AR_IDLE;
            arvalid <= 1'b0;
            araddr  <= '0;
            arprot  <= '0;
        end else begin
            case (state)
                AR_IDLE: begin
                    if (req_hs) begin
                        state   <= AR_BUSY;
                        arvalid <= 1'b1;
                        araddr  <= req_addr;
                        arprot  <= req_prot;
                    end
                end
                AR_BUSY: begin
                    if (req_hs) begin
                        arvalid <= 1'b1;
                        araddr  <= req_addr;
                        arprot  <= req_prot;
                    end else if (arready) begin
                        state   <= AR_IDLE;
                        arvalid <= 1'b0;
                    end
                end
                default: begin
                    state   <= AR_IDLE;
                    arvalid <= 1'b0;
                end
            endcase
        end
    end

    // Credits count reads accepted but not yet handed back to the requester.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits <= '0;
        end else if (req_hs && !rsp_hs) begin
            credits <= credits + CNT_W'(1);
        end else if (!req_hs && rsp_hs) begin
            credits <= credits - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (r_hs) begin
                wptr <= wptr + (PTR_W + 1)'(1);
            end
            if (rsp_hs) begin
                rptr <= rptr + (PTR_W + 1)'(1);
            end
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (r_hs) begin
            fifo_mem[wptr[PTR_W-1:0]].data <= rdata;
            fifo_mem[wptr[PTR_W-1:0]].resp <= rresp;
        end
    end

    // Idle-bus detection: credits equal to buffered beats means nothing is pending on R.
    always_comb begin
        tmo_nxt = tmo_cnt;
        if ((credits == occupancy) || r_hs) begin
            tmo_nxt = '0;
        end else if (tmo_cnt != '1) begin
            tmo_nxt = tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            tmo_cnt <= tmo_nxt;
            if (&tmo_nxt) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi4l_rd_master.sv
// Bench for axi4l_rd_master: queue-based reference of requests, AXI slave and
// response FIFO, compared every cycle, plus directed literal scenarios.
`timescale 1ns/1ps
module tb_axi4l_rd_master;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MO = 4;
    localparam int TW = 4;
    localparam int TMO_MAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_prot;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic          busy;
    logic          err_timeout;

    always #5 clk = ~clk;

    axi4l_rd_master #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .TMO_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .araddr(araddr), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp),
        .rvalid(rvalid), .rready(rready),
        .busy(busy), .err_timeout(err_timeout)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        int            cnt;
    } sbeat_t;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // reference state
    bit            m_arvalid;
    logic [AW-1:0] m_araddr;
    logic [2:0]    m_arprot;
    int            m_credits;
    logic [DW-1:0] m_fd[$];
    logic [1:0]    m_fr[$];
    int            m_tmo;
    bit            m_err;
    sbeat_t        slave_q[$];
    bit            r_shown;

    // stimulus knobs
    int            r_delay = 0;
    logic [DW-1:0] k_data[$];
    logic [1:0]    k_resp[$];

    // observations
    int            req_hs_n = 0;
    int            ar_hs_n = 0;
    int            ar_hs_cyc = 0;
    int            r_hs_cyc = 0;
    int            first_rsp_cyc = -1;
    int            err_cyc = -1;
    logic [DW-1:0] pop_data[$];
    logic [1:0]    pop_resp[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_arvalid = 1'b0;
        m_araddr  = '0;
        m_arprot  = '0;
        m_credits = 0;
        m_fd.delete();
        m_fr.delete();
        m_tmo     = 0;
        m_err     = 1'b0;
        slave_q.delete();
        r_shown   = 1'b0;
    endtask

    // One clock: drive at negedge, compare before posedge, advance reference at posedge.
    task automatic step(input bit rv, input logic [AW-1:0] a, input logic [2:0] p,
                        input bit ar, input bit rr, input bit ren);
        bit     exp_rq, exp_rr, rv_drv, req_hs, ar_hs, r_hs, rsp_hs;
        int     outst, tmo_new;
        sbeat_t hb, nb;
        @(negedge clk);
        req_valid = rv;
        req_addr  = a;
        req_prot  = p;
        arready   = ar;
        rsp_ready = rr;
        rv_drv    = (slave_q.size() > 0) && (slave_q[0].cnt == 0) && (ren || r_shown);
        if (rv_drv) begin
            hb      = slave_q[0];
            rvalid  = 1'b1;
            rdata   = hb.data;
            rresp   = hb.resp;
            r_shown = 1'b1;
        end else begin
            rvalid = 1'b0;
            rdata  = {$urandom, $urandom};
            rresp  = 2'($urandom);
        end
        exp_rq = (!m_arvalid || ar) && (m_credits < MO);
        exp_rr = (m_fd.size() < MO);
        #1;
        chk("req_ready", req_ready, exp_rq);
        chk("arvalid", arvalid, m_arvalid);
        chk("araddr", araddr, m_araddr);
        chk("arprot", arprot, m_arprot);
        chk("rready", rready, exp_rr);
        chk("rsp_valid", rsp_valid, m_fd.size() > 0);
        if (m_fd.size() > 0) begin
            chk("rsp_data", rsp_data, m_fd[0]);
            chk("rsp_resp", rsp_resp, m_fr[0]);
        end
        chk("busy", busy, (m_credits > 0) || m_arvalid);
        chk("err_timeout", err_timeout, m_err);
        if (rsp_valid === 1'b1 && first_rsp_cyc < 0) first_rsp_cyc = cyc;
        if (err_timeout === 1'b1 && err_cyc < 0) err_cyc = cyc;
        if (m_fd.size() > 0 && rr) begin
            pop_data.push_back(rsp_data);
            pop_resp.push_back(rsp_resp);
        end
        @(posedge clk);
        req_hs = rv && exp_rq;
        ar_hs  = m_arvalid && ar;
        r_hs   = rv_drv && exp_rr;
        rsp_hs = (m_fd.size() > 0) && rr;

        outst = m_credits - m_fd.size();
        if (outst == 0 || r_hs) tmo_new = 0;
        else if (m_tmo == TMO_MAX) tmo_new = TMO_MAX;
        else tmo_new = m_tmo + 1;
        if (tmo_new == TMO_MAX) m_err = 1'b1;
        m_tmo = tmo_new;

        if (r_hs) begin
            void'(slave_q.pop_front());
            r_shown  = 1'b0;
            r_hs_cyc = cyc;
        end
        for (int i = 0; i < slave_q.size(); i++) begin
            nb = slave_q[i];
            if (nb.cnt > 0) nb.cnt--;
            slave_q[i] = nb;
        end
        if (ar_hs) begin
            nb.data = (k_data.size() > 0) ? k_data.pop_front() : {$urandom, $urandom};
            nb.resp = (k_resp.size() > 0) ? k_resp.pop_front() : 2'($urandom);
            nb.cnt  = r_delay;
            slave_q.push_back(nb);
            ar_hs_n++;
            ar_hs_cyc = cyc;
        end
        if (rsp_hs) begin
            void'(m_fd.pop_front());
            void'(m_fr.pop_front());
        end
        if (r_hs) begin
            m_fd.push_back(hb.data);
            m_fr.push_back(hb.resp);
        end
        m_credits = m_credits + (req_hs ? 1 : 0) - (rsp_hs ? 1 : 0);
        if (req_hs) begin
            m_arvalid = 1'b1;
            m_araddr  = a;
            m_arprot  = p;
            req_hs_n++;
        end else if (ar_hs) begin
            m_arvalid = 1'b0;
        end
        cyc++;
    endtask

    // Reset also clears the slave side, as the interconnect resets together.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_prot  = '0;
        arready   = 1'b0;
        rsp_ready = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        rresp     = '0;
        repeat (n) @(posedge clk);
        model_clear();
        cyc = cyc + n;
        #1;
        rst_n = 1'b1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rready", rready, 1'b1);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_araddr", araddr, 64'h0);
        chk("rst_arprot", arprot, 3'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err_timeout", err_timeout, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rq, base_ar;
        logic [1:0] pr;
        logic [DW-1:0] pd;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_prot  = '0;
        arready   = 1'b0;
        rsp_ready = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        rresp     = '0;
        model_clear();
        do_reset(2);

        // single read
        k_data.push_back(64'hDEADBEEF_CAFEF00D);
        k_resp.push_back(2'd0);
        r_delay = 2;
        first_rsp_cyc = -1;
        pop_data.delete();
        pop_resp.delete();
        base_ar = ar_hs_n;
        step(1'b1, 64'h1000, 3'b000, 1'b1, 1'b1, 1'b1);
        #1;
        chk("single_arvalid_on", arvalid, 1'b1);
        chk("single_araddr", araddr, 64'h1000);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("single_arvalid_off", arvalid, 1'b0);
        chk("single_ar_count", ar_hs_n - base_ar, 1);
        idle(6);
        chk("single_rsp_latency", first_rsp_cyc - r_hs_cyc, 1);
        chk("single_pop_count", pop_data.size(), 1);
        if (pop_data.size() > 0) begin
            pd = pop_data[0];
            pr = pop_resp[0];
            chk("single_rsp_data", pd, 64'hDEADBEEF_CAFEF00D);
            chk("single_rsp_resp", pr, 2'd0);
        end

        // AR back-pressure
        r_delay = 1;
        base_rq = req_hs_n;
        step(1'b1, 64'h2000_0040, 3'b101, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, {$urandom, $urandom}, 3'($urandom), 1'b0, 1'b1, 1'b1);
            #1;
            chk("bp_arvalid", arvalid, 1'b1);
            chk("bp_araddr", araddr, 64'h2000_0040);
            chk("bp_arprot", arprot, 3'b101);
            chk("bp_req_ready", req_ready, 1'b0);
        end
        chk("bp_req_count", req_hs_n - base_rq, 1);
        idle(8);

        // outstanding limit
        r_delay = 0;
        base_rq = req_hs_n;
        base_ar = ar_hs_n;
        repeat (8) step(1'b1, {$urandom, $urandom}, 3'($urandom), 1'b1, 1'b0, 1'b0);
        chk("lim_ar_count", ar_hs_n - base_ar, 4);
        chk("lim_req_count", req_hs_n - base_rq, 4);
        #1;
        chk("lim_req_ready", req_ready, 1'b0);
        repeat (6) step(1'b1, {$urandom, $urandom}, 3'($urandom), 1'b1, 1'b0, 1'b1);
        chk("lim_req_count_full", req_hs_n - base_rq, 4);
        step(1'b1, {$urandom, $urandom}, 3'($urandom), 1'b1, 1'b1, 1'b1);
        repeat (4) step(1'b1, {$urandom, $urandom}, 3'($urandom), 1'b1, 1'b0, 1'b1);
        chk("lim_req_after_pop", req_hs_n - base_rq, 5);
        idle(15);

        // ordering with error responses
        r_delay = 1;
        k_resp.push_back(2'd0);
        k_resp.push_back(2'd2);
        k_resp.push_back(2'd3);
        pop_resp.delete();
        step(1'b1, 64'h100, 3'd0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 64'h108, 3'd1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 64'h110, 3'd2, 1'b1, 1'b1, 1'b1);
        idle(12);
        chk("ord_count", pop_resp.size(), 3);
        if (pop_resp.size() == 3) begin
            pr = pop_resp[0]; chk("ord_resp0", pr, 2'd0);
            pr = pop_resp[1]; chk("ord_resp1", pr, 2'd2);
            pr = pop_resp[2]; chk("ord_resp2", pr, 2'd3);
        end

        // timeout with the slave never answering
        r_delay = 0;
        err_cyc = -1;
        step(1'b1, 64'h3000, 3'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        base_ar = ar_hs_cyc;
        repeat (20) step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        chk("tmo_latency", err_cyc - base_ar, 15);
        base_rq = req_hs_n;
        step(1'b1, 64'h3100, 3'd0, 1'b1, 1'b1, 1'b0);
        chk("tmo_req_accepted", req_hs_n - base_rq, 1);

        // reset with two reads outstanding and one buffered
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'h3200, 3'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("mid_buffered", rsp_valid, 1'b1);
        do_reset(1);
        idle(3);

        // randomized traffic in phases of varying pressure
        for (int i = 0; i < 3000; i++) begin
            int ph;
            ph = (i / 400) % 3;
            r_delay = $urandom_range(0, 4);
            step($urandom_range(0, 99) < 60, {$urandom, $urandom}, 3'($urandom),
                 $urandom_range(0, 99) < ((ph == 0) ? 90 : 50),
                 $urandom_range(0, 99) < ((ph == 2) ? 20 : 75),
                 $urandom_range(0, 99) < 70);
        end
        idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
